expr_checker: RTL and testbench

Streaming arithmetic-expression recogniser, the parametrised successor of the single-digit `+`/`*` string FSM. It consumes one character per accepted cycle and flags whether the prefix received so far is a complete, well-formed expression. It adds multi-digit operands, the `-` operator, bounded parenthesis nesting, blank skipping, and an `=` terminator that reports a per-expression verdict and rearms for the next expression. It sits on the character stream between the input decoder and the result logic.

---
 rtl/expr_checker.sv | 175 +++++++++++++++++
 tb/tb_expr_checker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/expr_checker.sv
// expr_checker: streaming arithmetic-expression recogniser.
//
// Consumes one ASCII character per cycle with in_valid high (always ready)
// and reports whether the prefix received so far is a complete expression.
// Operands are 1..MAX_DIGITS decimal digits. The operators are + * -.
// Blanks are skipped. '=' ends the expression, pulses done with a verdict
// on match, and rearms the recogniser for the next expression.
//
// Build option:
//   EXPR_PAREN_EN  when defined, '(' and ')' nest up to MAX_DEPTH levels.
//                  When undefined, both characters are illegal and depth
//                  is tied to 0.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   clr          synchronous active-low reset
//   in_valid     in is consumed on this edge
//   in           character (bits above 7 must be 0 or it is illegal)
//   out          prefix so far is a complete expression
//   err          current expression rejected, held until '=' or reset
//   depth        current open-parenthesis count
//   done         one-cycle pulse after '=' is consumed
//   match        verdict for the finished expression, valid with done
//   dbg_state_o  raw FSM state (0 OPND, 1 NUM, 2 CLOSE, 3 ERR)
//
// Handshake: there is no back-pressure. A character is taken on every
// rising edge where in_valid is 1. While in_valid is 0 all state holds and
// done is 0.
module expr_checker #(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 7,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic               done,
  output logic               match,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic [DEPTH_W-1:0] depth_q;
  logic               done_q, done_d;
  logic               match_q, match_d;

  // Full-width compares, so any character with high bits set falls into
  // no class and is treated as illegal.
  logic is_digit, is_op, is_term, is_blank;
  assign is_digit = (in >= DATA_W'(48)) && (in <= DATA_W'(57));
  assign is_op    = (in == DATA_W'(43)) || (in == DATA_W'(42)) ||
                    (in == DATA_W'(45));
  assign is_term  = (in == DATA_W'(61));
  assign is_blank = (in == DATA_W'(32));

`ifdef EXPR_PAREN_EN
  logic [DEPTH_W-1:0] depth_d;
  logic is_open, is_close;
  assign is_open  = (in == DATA_W'(40));
  assign is_close = (in == DATA_W'(41));
`else
  assign depth_q = '0;
`endif

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
`ifdef EXPR_PAREN_EN
    depth_d = depth_q;
`endif
    done_d  = 1'b0;
    match_d = 1'b0;
    if (in_valid && !is_blank) begin
      if (is_term) begin
        // '=' finishes the expression from any state and rearms.
        done_d  = 1'b1;
        match_d = ((state_q == S_NUM) || (state_q == S_CLOSE)) &&
                  (depth_q == '0);
        state_d = S_OPND;
        dcnt_d  = '0;
`ifdef EXPR_PAREN_EN
        depth_d = '0;
`endif
      end else begin
        unique case (state_q)
          S_OPND: begin
            if (is_digit) begin
              state_d = S_NUM;
              dcnt_d  = CNT_W'(1);
            end
`ifdef EXPR_PAREN_EN
            else if (is_open) begin
              // Depth saturates: an open past the limit rejects instead.
              if (depth_q == DEPTH_W'(MAX_DEPTH)) state_d = S_ERR;
              else depth_d = depth_q + DEPTH_W'(1);
            end
`endif
            else begin
              state_d = S_ERR;
            end
          end
          S_NUM, S_CLOSE: begin
            if (is_op) begin
              state_d = S_OPND;
              dcnt_d  = '0;
            end else if (is_digit && (state_q == S_NUM)) begin
              if (dcnt_q == CNT_W'(MAX_DIGITS)) state_d = S_ERR;
              else dcnt_d = dcnt_q + CNT_W'(1);
            end
`ifdef EXPR_PAREN_EN
            else if (is_close) begin
              // Unbalanced close rejects, so depth never wraps below 0.
              if (depth_q != '0) begin
                depth_d = depth_q - DEPTH_W'(1);
                state_d = S_CLOSE;
              end else begin
                state_d = S_ERR;
              end
            end
`endif
            else begin
              state_d = S_ERR;
            end
          end
          default: ; // S_ERR holds until '='
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_OPND;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

`ifdef EXPR_PAREN_EN
  always_ff @(posedge clk) begin
    if (!clr) depth_q <= '0;
    else      depth_q <= depth_d;
  end
`endif

  assign out         = ((state_q == S_NUM) || (state_q == S_CLOSE)) &&
                       (depth_q == '0);
  assign err         = (state_q == S_ERR);
  assign depth       = depth_q;
  assign done        = done_q;
  assign match       = match_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_expr_checker.sv
// Directed testbench for expr_checker with the default parameters
// (MAX_DIGITS=4, MAX_DEPTH=7). Parenthesis vectors are selected by
// EXPR_PAREN_EN, matching the build of the design.
module tb_expr_checker;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in;
  logic       out, err, done, match;
  logic [2:0] depth;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  expr_checker dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in         (in),
    .out        (out),
    .err        (err),
    .depth      (depth),
    .done       (done),
    .match      (match),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one character, wait for the consuming edge, sample 1 ns later.
  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in       = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Send a string; eo/ee/ed hold the expected out, err and depth digits
  // after each character.
  task automatic seq(input string s, input string eo, input string ee,
                     input string ed, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      check($sformatf("%s[%0d].out", tag, i), 32'(out), 32'(eo[i] == "1"));
      check($sformatf("%s[%0d].err", tag, i), 32'(err), 32'(ee[i] == "1"));
      check($sformatf("%s[%0d].depth", tag, i), 32'(depth),
            32'(ed[i]) - 32'd48);
      check($sformatf("%s[%0d].done", tag, i), 32'(done), 32'd0);
    end
  endtask

  // Send '=' and check the verdict pulse plus the rearmed state.
  task automatic term(input logic em, input string tag);
    send("=");
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".match"}, 32'(match), 32'(em));
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".out"}, 32'(out), 32'd0);
    check({tag, ".depth"}, 32'(depth), 32'd0);
    check({tag, ".state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic check_idle_regs(input string tag);
    check({tag, ".state"}, 32'(dbg_state), 32'd0);
    check({tag, ".out"}, 32'(out), 32'd0);
    check({tag, ".err"}, 32'(err), 32'd0);
    check({tag, ".depth"}, 32'(depth), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".match"}, 32'(match), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with a character presented: clr must win.
    clr      = 1'b0;
    in_valid = 1'b1;
    in       = "1";
    repeat (2) @(posedge clk);
    #1;
    check_idle_regs("reset");
    clr      = 1'b1;
    in_valid = 1'b0;

    // Basic expression, then done drops on an idle cycle.
    seq("12+3*45", "1101011", "0000000", "0000000", "t1");
    term(1'b1, "t1.eq");
    idle();
    check("t1.done_drop", 32'(done), 32'd0);
    check("t1.match_drop", 32'(match), 32'd0);

    // Operand length limit.
    seq("12345", "11110", "00001", "00000", "len");
    term(1'b0, "len.eq");

    // Term straight after an operator.
    seq("1+", "10", "00", "00", "dangle");
    term(1'b0, "dangle.eq");

    // Term on an empty expression.
    term(1'b0, "empty.eq");

    // Illegal character.
    seq("7a", "10", "01", "00", "illegal");
    term(1'b0, "illegal.eq");

    // Blanks and an in_valid gap with garbage on the bus.
    seq("1 +", "110", "000", "000", "gap");
    in = "9";
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("gap.hold%0d.out", i), 32'(out), 32'd0);
      check($sformatf("gap.hold%0d.err", i), 32'(err), 32'd0);
      check($sformatf("gap.hold%0d.done", i), 32'(done), 32'd0);
    end
    seq(" 2", "01", "00", "00", "gap2");
    term(1'b1, "gap.eq");

    // Back-to-back expressions with no idle cycle.
    seq("5", "1", "0", "0", "b2b_a");
    term(1'b1, "b2b_a.eq");
    seq("6", "1", "0", "0", "b2b_b");
    term(1'b1, "b2b_b.eq");

`ifdef EXPR_PAREN_EN
    seq("(1-(2))*7", "000000101", "000000000", "111221000", "paren");
    term(1'b1, "paren.eq");

    seq("(1+2))", "000010", "000001", "111100", "unbal");
    term(1'b0, "unbal.eq");
    idle();
    check("unbal.err_clear", 32'(err), 32'd0);

    seq("((((((((", "00000000", "00000001", "12345677", "deep");
    term(1'b0, "deep.eq");

    seq("(3+", "000", "000", "111", "clr");
`else
    // Parentheses are illegal in this build.
    seq("(", "0", "1", "0", "noparen_open");
    term(1'b0, "noparen_open.eq");
    seq("1)", "10", "01", "00", "noparen_close");
    term(1'b0, "noparen_close.eq");

    seq("3+", "10", "00", "00", "clr");
`endif
    // Mid-expression clear with a digit presented on the same edge.
    clr      = 1'b0;
    in_valid = 1'b1;
    in       = "5";
    @(posedge clk);
    #1;
    clr      = 1'b1;
    in_valid = 1'b0;
    check_idle_regs("clr.mid");
    seq("7", "1", "0", "0", "clr.after");
    term(1'b1, "clr.after.eq");

    // Clear during the done pulse.
    seq("4", "1", "0", "0", "clrdone");
    term(1'b1, "clrdone.eq");
    clr      = 1'b0;
    in_valid = 1'b1;
    in       = "5";
    @(posedge clk);
    #1;
    clr      = 1'b1;
    in_valid = 1'b0;
    check_idle_regs("clrdone.cleared");
    seq("8", "1", "0", "0", "clrdone.after");
    term(1'b1, "clrdone.after.eq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
